vc_fifo: RTL
============

# vc_fifo

Per-virtual-channel buffer in the PCIe transaction layer, sitting directly downstream of the referee. The referee asserts `push_N` on one of four instances to write the transaction word, and reads each instance's `almost_full` and `empty` flags to throttle its arbitration. The block is a synchronous circular-buffer FIFO with registered read data, occupancy-derived status flags, and sticky overflow/underflow error reporting.

## Interface
Parameters:
- `DATA_WIDTH`, 12: transaction word width.
- `ADDR_WIDTH`, 3: pointer width; `DEPTH = 2**ADDR_WIDTH` (8 entries).
- `AF_THRESH`, 6: `almost_full` asserts when occupancy ≥ this value.
- `AE_THRESH`, 2: `almost_empty` asserts when occupancy ≤ this value.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in`  in  DATA_WIDTH  word to write.
- `push`  in  1  write request.
- `pop`  in  1  read request.
- `data_out`  out  DATA_WIDTH  registered read data.
- `valid_out`  out  1  one-cycle strobe; `data_out` is new this cycle.
- `empty`  out  1  occupancy == 0.
- `full`  out  1  occupancy == DEPTH.
- `almost_full`  out  1  occupancy ≥ AF_THRESH.
- `almost_empty`  out  1  occupancy ≤ AE_THRESH.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `fifo_error`  out  1  sticky; set on overflow or underflow attempt.

## Operation
- State: memory array of DEPTH×DATA_WIDTH, `wr_ptr` and `rd_ptr` (ADDR_WIDTH bits each, wrapping naturally from DEPTH−1 to 0), and a registered `count`.
- Pop is accepted iff `count > 0`. When accepted, `data_out` ← mem[rd_ptr], `rd_ptr` advances, and `valid_out` = 1 on the next cycle.
- Push is accepted iff `count < DEPTH`, or when a pop is accepted in the same cycle. When accepted, mem[wr_ptr] ← `data_in` and `wr_ptr` advances.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - unchanged when both or neither are accepted.
- Full with push and pop together: both are accepted, `count` stays at DEPTH, and the oldest word is output.
- Empty with push and pop together: the push is accepted, the pop is rejected, `count` becomes 1, `valid_out` stays 0, and `fifo_error` is set.
- A rejected push (full, no pop) discards the data, leaves memory and pointers unchanged, and sets `fifo_error`.
- A rejected pop (empty) leaves `data_out` holding its previous value and sets `fifo_error`.
- `fifo_error` is cleared only by reset.
- `data_out` holds its last value whenever no pop is accepted.
- All flags are combinational decodes of the registered `count`, with no glitch paths from `push` or `pop`.

## Timing
- Reset (`reset` low, asynchronous):
  - `wr_ptr`, `rd_ptr`, `count`, `data_out`, `valid_out`, and `fifo_error` clear to 0.
  - Flags: `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0.
  - Memory contents are not reset.
- Reset asserted mid-operation clears state immediately, independent of `clk`. Contents in flight are discarded. Operation resumes on the first rising edge after `reset` returns high.
- Write-to-flag latency is 1 cycle: after push at edge k, `empty` falls and `count` increments after edge k.
- Write-to-read latency: the earliest pop of a word is the cycle after it is written. Its data appears on `data_out` one edge after the pop is sampled.
- Flag transitions:
  - `almost_full` rises on the edge where `count` goes AF_THRESH−1 → AF_THRESH.
  - `almost_empty` falls on the edge where `count` goes AE_THRESH → AE_THRESH+1.
- Throughput is one push and one pop per cycle sustained, with no bubbles.

## Test plan
- Reset check: hold `reset`=0 for 2 cycles → `count`=0, `empty`=1, `almost_empty`=1, `full`=0, `data_out`=0, `fifo_error`=0.
- Fill then drain: push 0x001..0x008 on consecutive cycles, then pop 8 times.
  - During fill: `almost_empty` falls after the 3rd push, `almost_full` rises after the 6th, and `full` rises after the 8th.
  - During drain: `data_out` returns 0x001..0x008 in order with `valid_out` high each cycle, and `empty`=1 after the last pop.
- Overflow: with the FIFO full, push 0xABC without pop → `count` stays 8, `fifo_error`=1, and the next 8 pops never return 0xABC.
- Underflow: with the FIFO empty, assert pop → `valid_out`=0, `data_out` unchanged, `fifo_error`=1.
- Simultaneous push and pop:
  - At count 4: `count` stays 4 and output order is preserved.
  - At full: `count` stays 8 with no error.
  - At empty: `count`→1 and `fifo_error`=1.
- Wrap and async reset: run 20 push/pop pairs so the pointers wrap at least twice, checking data order against a scoreboard. Then drop `reset` between clock edges at count 5 → all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/vc_fifo.sv
// vc_fifo: per-virtual-channel circular-buffer FIFO with registered read data,
// occupancy-derived status flags and a sticky overflow/underflow error flag.
module vc_fifo #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_THRESH  = 6,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  fifo_error
);

    localparam int unsigned          DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]  DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]  AF_CNT    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]  AE_CNT    = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  reject;

    // Acceptance decode: a push into a full FIFO is allowed only when a pop frees a slot in the same cycle
    always_comb begin
        pop_ok  = pop && (count != '0);
        push_ok = push && ((count != DEPTH_CNT) || pop_ok);
        reject  = (push && !push_ok) || (pop && !pop_ok);
    end

    // Storage array; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy, read data and error state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            fifo_error <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
                default: count <= count;
            endcase
            if (reject) begin
                fifo_error <= 1'b1;
            end
        end
    end

    // Status flags decode only the registered occupancy
    always_comb begin
        empty        = (count == '0);
        full         = (count == DEPTH_CNT);
        almost_full  = (count >= AF_CNT);
        almost_empty = (count <= AE_CNT);
    end

endmodule
